ble_cmd_parser: RTL and testbench
=================================

// Module: ble_cmd_parser
// PURPOSE
//  Byte-stream command parser for the BB8 BLE link, upstream of bluetooth_to_motor and the PID loop.
//  Consumes bytes from the UART receiver and decodes fixed 5-byte frames.
//  Validates each frame and holds the PID gains, pitch/yaw setpoints and init flags in registers.
//  Also runs a link watchdog: setpoints are forced to zero when commands stop arriving.
// PARAMETERS
//  BYTE_TIMEOUT  100_000     max clocks between bytes of one frame (1 ms @100 MHz)
//  LINK_TIMEOUT  50_000_000  clocks without a good frame before failsafe (0.5 s)
// PORTS
//  clock                 in   1  system clock, 100 MHz
//  reset_n               in   1  asynchronous, active-low reset
//  rx_valid              in   1  one-cycle strobe: rx_data holds a received byte
//  rx_data               in   8  received byte
//  pitch_kP/kI/kD        out  9  signed pitch PID gains
//  yaw_kP/kI/kD          out  9  signed yaw PID gains
//  set_pitch, set_yaw    out  9  signed setpoints
//  init_flags            out  8  motor/MPU enable flags
//  init_mpu              out  1  one-cycle MPU initialise pulse
//  cmd_valid             out  1  one-cycle pulse: a register was updated
//  chk_err               out  1  one-cycle pulse: checksum fail, frame dropped
//  err_count             out  8  saturating count of checksum, unknown-ID and timeout errors
//  link_lost             out  1  high while the watchdog has expired
// BEHAVIOUR
//  Reset
//   - All outputs reset to 0; FSM goes to HUNT; counters reset to 0.
//   - link_lost resets to 1 (no link until the first good frame).
//  Frame format
//   - Bytes: SYNC=0xA5, ID, HI, LO, CHK.
//   - Good frame: CHK == ID^HI^LO.
//   - Payload D = signed {HI,LO}, saturated to 9 bits: D>255 -> 255, D<-256 -> -256.
//  FSM (advances only on rx_valid)
//   - HUNT -> ID on 0xA5; any other byte is ignored.
//   - ID: byte 0xA5 means re-sync, stay in ID; otherwise latch ID, go to HI.
//   - HI -> LO -> CHK, latching each byte.
//   - CHK: evaluate the frame, then return to HUNT.
//  Byte timeout
//   - In ID, HI, LO or CHK, if BYTE_TIMEOUT clocks pass with no rx_valid: go to HUNT, err_count++.
//   - The gap counter clears on every rx_valid.
//  Register map (ID)
//   - 0x01-0x03 pitch kP/kI/kD; 0x04-0x06 yaw kP/kI/kD.
//   - 0x07 set_pitch; 0x08 set_yaw.
//   - 0x09 init_flags <= LO (no saturation).
//   - 0x0A init_mpu pulse; payload ignored.
//  Latency
//   - Register update, cmd_valid and init_mpu all appear 1 clock after the rx_valid carrying CHK.
//   - Only one register is written per frame.
//  Errors
//   - Bad CHK: chk_err pulse, err_count++, no register changes.
//   - Good CHK with unknown ID: err_count++, no cmd_valid.
//   - err_count saturates at 255.
//  Watchdog
//   - A counter clears on every good, known frame.
//   - At LINK_TIMEOUT it sets link_lost=1 and forces set_pitch=set_yaw=0.
//   - Gains and init_flags are held.
//   - The next good frame clears link_lost. A 0x07/0x08 frame clears it in the same cycle the new value is written.
//  Simultaneous events
//   - If the byte timeout and rx_valid coincide, rx_valid wins: the gap counter clears.
//   - If the watchdog expires and a good frame completes in the same cycle, the frame wins.
//  Reset mid-frame: the partial frame is discarded and all registers are cleared.
// STRUCTURE
//  bb8_pkg holds:
//   - BLE_SYNC constant (0xA5).
//   - ble_cmd_e enum (IDs 0x01-0x0A).
//   - parser state enum {HUNT, ID, HI, LO, CHK}.
//   - function sat_s16_to_s9.
//  No sub-module: one FSM, two counters (byte gap, link watchdog) and an output register bank.
// TESTING
//  - Send A5 07 00 64 63 -> set_pitch=100 and cmd_valid pulses once, 1 clock after the CHK byte.
//  - Send A5 08 FF 00 F7 (D=-256) and A5 08 80 00 88 (D=-32768) -> set_yaw=-256 in both cases.
//  - Send A5 01 00 05 00 (bad CHK) -> chk_err pulse, err_count=1, pitch_kP unchanged.
//  - Send A5 07 00 then idle BYTE_TIMEOUT+1 clocks, then a good frame -> err_count+1, and the good frame is accepted.
//  - Send A5 07 00 32 35, then idle LINK_TIMEOUT clocks -> link_lost=1, set_pitch=0, gains held.
//  - Send 12 A5 A5 0A 00 00 0A -> init_mpu pulses for 1 clock; assert reset_n low mid-frame -> all outputs 0.

Source files
------------

// File: rtl/bb8_pkg.sv
// Shared types and helpers for the BB8 BLE command link.
package bb8_pkg;

   localparam logic [7:0]  BLE_SYNC = 8'hA5;
   localparam int unsigned GAIN_W   = 9;

   typedef enum logic [7:0] {
      CMD_PITCH_KP   = 8'h01,
      CMD_PITCH_KI   = 8'h02,
      CMD_PITCH_KD   = 8'h03,
      CMD_YAW_KP     = 8'h04,
      CMD_YAW_KI     = 8'h05,
      CMD_YAW_KD     = 8'h06,
      CMD_SET_PITCH  = 8'h07,
      CMD_SET_YAW    = 8'h08,
      CMD_INIT_FLAGS = 8'h09,
      CMD_INIT_MPU   = 8'h0A
   } ble_cmd_e;

   typedef enum logic [2:0] {
      ST_HUNT,
      ST_ID,
      ST_HI,
      ST_LO,
      ST_CHK
   } parser_state_e;

   typedef struct packed {
      logic [7:0] id;
      logic [7:0] hi;
      logic [7:0] lo;
   } ble_frame_t;

   // Clamp a signed 16-bit payload into the 9-bit register range.
   function automatic logic signed [GAIN_W-1:0] sat_s16_to_s9(input logic signed [15:0] v);
      if (v > 16'sd255)
         return $signed(9'h0FF);
      else if (v < -16'sd256)
         return $signed(9'h100);
      else
         return v[GAIN_W-1:0];
   endfunction

endpackage

// File: rtl/ble_cmd_parser.sv
// Decodes 5-byte BLE command frames into PID gain / setpoint registers,
// with a per-byte gap timeout and a link watchdog that zeroes setpoints.
module ble_cmd_parser
   import bb8_pkg::*;
#(
   parameter int unsigned BYTE_TIMEOUT = 100_000,
   parameter int unsigned LINK_TIMEOUT = 50_000_000
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     rx_valid,
   input  logic [7:0]               rx_data,
   output logic signed [GAIN_W-1:0] pitch_kP,
   output logic signed [GAIN_W-1:0] pitch_kI,
   output logic signed [GAIN_W-1:0] pitch_kD,
   output logic signed [GAIN_W-1:0] yaw_kP,
   output logic signed [GAIN_W-1:0] yaw_kI,
   output logic signed [GAIN_W-1:0] yaw_kD,
   output logic signed [GAIN_W-1:0] set_pitch,
   output logic signed [GAIN_W-1:0] set_yaw,
   output logic [7:0]               init_flags,
   output logic                     init_mpu,
   output logic                     cmd_valid,
   output logic                     chk_err,
   output logic [7:0]               err_count,
   output logic                     link_lost
);

   localparam int unsigned GAP_W  = $clog2(BYTE_TIMEOUT + 1);
   localparam int unsigned LINK_W = $clog2(LINK_TIMEOUT + 1);

   parser_state_e            state;
   parser_state_e            state_next;
   ble_frame_t               frame;
   logic [GAP_W-1:0]         gap_cnt;
   logic [LINK_W-1:0]        link_cnt;

   logic                     byte_timeout_c;
   logic                     frame_done_c;
   logic                     chk_ok_c;
   logic                     known_c;
   logic                     commit_c;
   logic                     err_inc_c;
   logic                     link_expire_c;
   logic signed [GAIN_W-1:0] payload_c;

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         state <= ST_HUNT;
      else
         state <= state_next;
   end

   // Next-state: advance on each byte, abandon the frame on a gap timeout
   always_comb begin
      state_next     = state;
      byte_timeout_c = 1'b0;
      frame_done_c   = 1'b0;
      case (state)
         ST_HUNT: if (rx_valid && rx_data == BLE_SYNC) state_next = ST_ID;
         ST_ID:   if (rx_valid && rx_data != BLE_SYNC) state_next = ST_HI;
         ST_HI:   if (rx_valid) state_next = ST_LO;
         ST_LO:   if (rx_valid) state_next = ST_CHK;
         ST_CHK: begin
            if (rx_valid) begin
               state_next   = ST_HUNT;
               frame_done_c = 1'b1;
            end
         end
         default: state_next = ST_HUNT;
      endcase
      if (state != ST_HUNT && !rx_valid && gap_cnt == GAP_W'(BYTE_TIMEOUT - 1)) begin
         byte_timeout_c = 1'b1;
         state_next     = ST_HUNT;
      end
   end

   // Frame evaluation on the CHK byte
   always_comb begin
      chk_ok_c      = (rx_data == (frame.id ^ frame.hi ^ frame.lo));
      known_c       = (frame.id inside {[8'h01:8'h0A]});
      payload_c     = sat_s16_to_s9({frame.hi, frame.lo});
      commit_c      = frame_done_c && chk_ok_c && known_c;
      err_inc_c     = byte_timeout_c || (frame_done_c && !(chk_ok_c && known_c));
      link_expire_c = !commit_c && (link_cnt == LINK_W'(LINK_TIMEOUT - 1));
   end

   // Byte capture
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         frame <= '0;
      end else if (rx_valid) begin
         case (state)
            ST_ID:   if (rx_data != BLE_SYNC) frame.id <= rx_data;
            ST_HI:   frame.hi <= rx_data;
            ST_LO:   frame.lo <= rx_data;
            default: ;
         endcase
      end
   end

   // Inter-byte gap counter; only meaningful while inside a frame
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         gap_cnt <= '0;
      else if (rx_valid || state == ST_HUNT || byte_timeout_c)
         gap_cnt <= '0;
      else
         gap_cnt <= gap_cnt + GAP_W'(1);
   end

   // Link watchdog; parks at LINK_TIMEOUT once expired
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         link_cnt <= '0;
      else if (commit_c)
         link_cnt <= '0;
      else if (link_cnt != LINK_W'(LINK_TIMEOUT))
         link_cnt <= link_cnt + LINK_W'(1);
   end

   // Output register bank
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pitch_kP   <= '0;
         pitch_kI   <= '0;
         pitch_kD   <= '0;
         yaw_kP     <= '0;
         yaw_kI     <= '0;
         yaw_kD     <= '0;
         set_pitch  <= '0;
         set_yaw    <= '0;
         init_flags <= '0;
         init_mpu   <= 1'b0;
         cmd_valid  <= 1'b0;
         chk_err    <= 1'b0;
         err_count  <= '0;
         link_lost  <= 1'b1;
      end else begin
         init_mpu  <= 1'b0;
         cmd_valid <= 1'b0;
         chk_err   <= frame_done_c && !chk_ok_c;
         if (err_inc_c && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
         if (commit_c) begin
            cmd_valid <= 1'b1;
            link_lost <= 1'b0;
            case (frame.id)
               CMD_PITCH_KP:   pitch_kP   <= payload_c;
               CMD_PITCH_KI:   pitch_kI   <= payload_c;
               CMD_PITCH_KD:   pitch_kD   <= payload_c;
               CMD_YAW_KP:     yaw_kP     <= payload_c;
               CMD_YAW_KI:     yaw_kI     <= payload_c;
               CMD_YAW_KD:     yaw_kD     <= payload_c;
               CMD_SET_PITCH:  set_pitch  <= payload_c;
               CMD_SET_YAW:    set_yaw    <= payload_c;
               CMD_INIT_FLAGS: init_flags <= frame.lo;
               CMD_INIT_MPU:   init_mpu   <= 1'b1;
               default: ;
            endcase
         end else if (link_expire_c) begin
            // Gains and flags survive a link loss; only motion targets are zeroed
            link_lost <= 1'b1;
            set_pitch <= '0;
            set_yaw   <= '0;
         end
      end
   end

endmodule

// File: tb/tb_ble_cmd_parser.sv
// Self-checking bench for ble_cmd_parser: directed vector table, corner
// sequences, then random frames against a frame-level reference model.
module tb_ble_cmd_parser;
   import bb8_pkg::*;

   localparam int unsigned BT = 40;
   localparam int unsigned LT = 3000;

   logic              clock = 1'b0;
   logic              reset_n;
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic signed [8:0] pitch_kP, pitch_kI, pitch_kD;
   logic signed [8:0] yaw_kP, yaw_kI, yaw_kD;
   logic signed [8:0] set_pitch, set_yaw;
   logic [7:0]        init_flags, err_count;
   logic              init_mpu, cmd_valid, chk_err, link_lost;

   always #5 clock = ~clock;

   ble_cmd_parser #(.BYTE_TIMEOUT(BT), .LINK_TIMEOUT(LT)) dut (
      .clock(clock), .reset_n(reset_n), .rx_valid(rx_valid), .rx_data(rx_data),
      .pitch_kP(pitch_kP), .pitch_kI(pitch_kI), .pitch_kD(pitch_kD),
      .yaw_kP(yaw_kP), .yaw_kI(yaw_kI), .yaw_kD(yaw_kD),
      .set_pitch(set_pitch), .set_yaw(set_yaw), .init_flags(init_flags),
      .init_mpu(init_mpu), .cmd_valid(cmd_valid), .chk_err(chk_err),
      .err_count(err_count), .link_lost(link_lost)
   );

   int tests = 0, fails = 0;
   int n_cv = 0, n_ce = 0, n_im = 0;   // observed pulse-cycles
   int e_cv = 0, e_ce = 0, e_im = 0;   // expected pulse-cycles
   int m_reg [1:9];
   int m_err, m_link;

   always @(negedge clock) begin
      if (reset_n) begin
         n_cv += int'(cmd_valid);
         n_ce += int'(chk_err);
         n_im += int'(init_mpu);
      end
   end

   typedef struct {
      logic [7:0] id, hi, lo, chk;
      int sel, exp, exp_err, dcv, dce;
   } vec_t;
   vec_t vec [14];

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int get_out(input int s);
      case (s)
         1: return int'(pitch_kP);
         2: return int'(pitch_kI);
         3: return int'(pitch_kD);
         4: return int'(yaw_kP);
         5: return int'(yaw_kI);
         6: return int'(yaw_kD);
         7: return int'(set_pitch);
         8: return int'(set_yaw);
         9: return int'(init_flags);
         10: return int'(err_count);
         default: return int'(link_lost);
      endcase
   endfunction

   function automatic string sel_name(input int s);
      case (s)
         1: return "pitch_kP";  2: return "pitch_kI";  3: return "pitch_kD";
         4: return "yaw_kP";    5: return "yaw_kI";    6: return "yaw_kD";
         7: return "set_pitch"; 8: return "set_yaw";   9: return "init_flags";
         10: return "err_count";
         default: return "link_lost";
      endcase
   endfunction

   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clock);
      rx_valid = 1'b0;
      repeat (gap) @(negedge clock);
   endtask

   task automatic send_frame(input logic [7:0] id, hi, lo, chk);
      send_byte(BLE_SYNC, 1);
      send_byte(id, 0);
      send_byte(hi, 2);
      send_byte(lo, 1);
      send_byte(chk, 0);
      @(negedge clock);
   endtask

   task automatic check_pulses(input string tag);
      check({tag, " cmd_valid cycles"}, n_cv, e_cv);
      check({tag, " chk_err cycles"}, n_ce, e_ce);
      check({tag, " init_mpu cycles"}, n_im, e_im);
   endtask

   // Reference model: whole-frame effects computed from the frame contents
   function automatic int m_sat(input logic [7:0] hi, input logic [7:0] lo);
      logic signed [15:0] s;
      int d;
      s = {hi, lo};
      d = s;
      if (d > 255) d = 255;
      else if (d < -256) d = -256;
      return d;
   endfunction

   task automatic m_reset();
      for (int i = 1; i <= 9; i++) m_reg[i] = 0;
      m_err  = 0;
      m_link = 1;
   endtask

   task automatic m_error();
      if (m_err < 255) m_err++;
   endtask

   task automatic m_frame(input logic [7:0] id, hi, lo, chk);
      if (chk != (id ^ hi ^ lo)) begin
         m_error();
         e_ce++;
      end else if (id >= 8'd1 && id <= 8'd10) begin
         e_cv++;
         m_link = 0;
         if (id == 8'd9) m_reg[9] = int'(lo);
         else if (id == 8'd10) e_im++;
         else m_reg[id] = m_sat(hi, lo);
      end else begin
         m_error();
      end
   endtask

   task automatic check_model(input string tag);
      for (int s = 1; s <= 9; s++) check({tag, " ", sel_name(s)}, get_out(s), m_reg[s]);
      check({tag, " err_count"}, int'(err_count), m_err);
      check({tag, " link_lost"}, int'(link_lost), m_link);
      check_pulses(tag);
   endtask

   initial begin
      logic [7:0] q[$];
      logic [7:0] id, hi, lo, chk;
      int kind;

      reset_n  = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      m_reset();
      check_model("reset");

      // id, hi, lo, chk, observed output, expected, err_count, dcv, dce
      vec[0]  = '{8'h07, 8'h00, 8'h64, 8'h63, 7, 100, 0, 1, 0};
      vec[1]  = '{8'h08, 8'hFF, 8'h00, 8'hF7, 8, -256, 0, 1, 0};
      vec[2]  = '{8'h08, 8'h80, 8'h00, 8'h88, 8, -256, 0, 1, 0};
      vec[3]  = '{8'h01, 8'h00, 8'h05, 8'h00, 1, 0, 1, 0, 1};
      vec[4]  = '{8'h01, 8'h00, 8'h05, 8'h04, 1, 5, 1, 1, 0};
      vec[5]  = '{8'h02, 8'h01, 8'h2C, 8'h2F, 2, 255, 1, 1, 0};
      vec[6]  = '{8'h03, 8'hFF, 8'h9C, 8'h60, 3, -100, 1, 1, 0};
      vec[7]  = '{8'h04, 8'h7F, 8'hFF, 8'h84, 4, 255, 1, 1, 0};
      vec[8]  = '{8'h05, 8'hFE, 8'hFF, 8'h04, 5, -256, 1, 1, 0};
      vec[9]  = '{8'h06, 8'h00, 8'hFF, 8'hF9, 6, 255, 1, 1, 0};
      vec[10] = '{8'h09, 8'h12, 8'hC3, 8'hD8, 9, 195, 1, 1, 0};
      vec[11] = '{8'h0B, 8'h00, 8'h00, 8'h0B, 1, 5, 2, 0, 0};
      vec[12] = '{8'h07, 8'h00, 8'hFF, 8'hF8, 7, 255, 2, 1, 0};
      vec[13] = '{8'h07, 8'hFF, 8'h01, 8'hF9, 7, -255, 2, 1, 0};

      for (int i = 0; i < 14; i++) begin
         send_frame(vec[i].id, vec[i].hi, vec[i].lo, vec[i].chk);
         e_cv += vec[i].dcv;
         e_ce += vec[i].dce;
         check($sformatf("vec%0d %s", i, sel_name(vec[i].sel)), get_out(vec[i].sel), vec[i].exp);
         check($sformatf("vec%0d err_count", i), int'(err_count), vec[i].exp_err);
         check_pulses($sformatf("vec%0d", i));
      end
      check("link_lost after good frames", int'(link_lost), 0);

      // Junk before sync and a repeated sync before the ID
      foreach (q[i]) q.delete();
      q = '{8'h12, 8'hA5, 8'hA5, 8'h0A, 8'h00, 8'h00, 8'h0A};
      foreach (q[i]) send_byte(q[i], 1);
      @(negedge clock);
      e_cv++; e_im++;
      check_pulses("init_mpu resync");

      // Stall mid-frame past the byte timeout, then a clean frame
      send_byte(BLE_SYNC, 0);
      send_byte(8'h07, 0);
      send_byte(8'h00, 0);
      repeat (BT + 1) @(negedge clock);
      check("byte timeout err_count", int'(err_count), 3);
      send_frame(8'h07, 8'h00, 8'h32, 8'h35);
      e_cv++;
      check("after timeout set_pitch", int'(set_pitch), 50);
      check("after timeout err_count", int'(err_count), 3);

      // Byte lands exactly on the timeout clock: the byte must win
      send_byte(BLE_SYNC, BT - 1);
      send_byte(8'h07, BT - 1);
      send_byte(8'h00, BT - 1);
      send_byte(8'h14, BT - 1);
      send_byte(8'h13, 0);
      @(negedge clock);
      e_cv++;
      check("coincide set_pitch", int'(set_pitch), 20);
      check("coincide err_count", int'(err_count), 3);
      check_pulses("coincide");

      // Watchdog
      repeat (LT - 20) @(negedge clock);
      check("watchdog early link_lost", int'(link_lost), 0);
      check("watchdog early set_pitch", int'(set_pitch), 20);
      repeat (40) @(negedge clock);
      check("watchdog link_lost", int'(link_lost), 1);
      check("watchdog set_pitch", int'(set_pitch), 0);
      check("watchdog set_yaw", int'(set_yaw), 0);
      check("watchdog pitch_kP held", int'(pitch_kP), 5);
      check("watchdog yaw_kI held", int'(yaw_kI), -256);
      check("watchdog init_flags held", int'(init_flags), 195);
      send_frame(8'h08, 8'h00, 8'h10, 8'h18);
      e_cv++;
      check("relink link_lost", int'(link_lost), 0);
      check("relink set_yaw", int'(set_yaw), 16);
      check("relink set_pitch", int'(set_pitch), 0);

      // Reset in the middle of a frame
      send_byte(BLE_SYNC, 0);
      send_byte(8'h07, 0);
      send_byte(8'h00, 0);
      reset_n = 1'b0;
      @(negedge clock);
      m_reset();
      for (int s = 1; s <= 9; s++) check({"midreset ", sel_name(s)}, get_out(s), 0);
      check("midreset err_count", int'(err_count), 0);
      check("midreset link_lost", int'(link_lost), 1);
      check("midreset pulses", int'(cmd_valid) + int'(chk_err) + int'(init_mpu), 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);
      send_byte(8'h32, 0);
      send_byte(8'h35, 0);
      @(negedge clock);
      check_model("post-reset tail");

      // Random frames against the model
      for (int n = 0; n < 150; n++) begin
         q.delete();
         kind = int'($urandom_range(0, 9));
         for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
            logic [7:0] junk;
            do junk = 8'($urandom_range(0, 255)); while (junk == BLE_SYNC);
            q.push_back(junk);
         end
         q.push_back(BLE_SYNC);
         if ($urandom_range(0, 3) == 0) q.push_back(BLE_SYNC);
         if (kind == 6) begin
            do id = 8'($urandom_range(0, 255)); while ((id >= 8'd1 && id <= 8'd10) || id == BLE_SYNC);
         end else begin
            id = 8'($urandom_range(1, 10));
         end
         if ($urandom_range(0, 3) == 0) begin
            q = {q};
            case ($urandom_range(0, 5))
               0: hi = 8'h00; 1: hi = 8'hFF; 2: hi = 8'h7F;
               3: hi = 8'h80; 4: hi = 8'h01; default: hi = 8'hFE;
            endcase
         end else begin
            hi = 8'($urandom_range(0, 255));
         end
         lo  = 8'($urandom_range(0, 255));
         chk = id ^ hi ^ lo;
         if (kind == 7 || kind == 8) chk = chk ^ 8'($urandom_range(1, 255));
         q.push_back(id);
         if (kind == 9) begin
            if ($urandom_range(0, 1) == 1) q.push_back(hi);
            if ($urandom_range(0, 1) == 1) q.push_back(lo);
            foreach (q[i]) send_byte(q[i], int'($urandom_range(0, 3)));
            repeat (BT + 2) @(negedge clock);
            m_error();
         end else begin
            q.push_back(hi);
            q.push_back(lo);
            q.push_back(chk);
            foreach (q[i]) send_byte(q[i], (i == q.size() - 1) ? 0 : int'($urandom_range(0, 3)));
            @(negedge clock);
            m_frame(id, hi, lo, chk);
         end
         check_model($sformatf("rand%0d", n));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
